// File: rtl/npu_dma_pkg.sv
// Shared types and constants for the NPU copy DMA: FSM states, AXI beat
// geometry and the 4 KB boundary helper.
package npu_dma_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_ADDR,
      ST_RD_DATA,
      ST_WR_ADDR,
      ST_WR_DATA,
      ST_WR_RESP,
      ST_DONE
   } dma_state_e;

   localparam int          BEAT_BYTES   = 32;
   localparam logic [2:0]  AXI_SIZE_32B = 3'd5;
   localparam logic [12:0] BOUNDARY_4K  = 13'd4096;

   // Beats left before a beat-aligned address reaches the next 4 KB page (1..128).
   function automatic logic [7:0] beats_to_4k(input logic [11:0] page_off);
      logic [12:0] gap;
      gap = BOUNDARY_4K - {1'b0, page_off};
      return gap[12:5];
   endfunction

endpackage

// File: rtl/npu_dma_beat_buf.sv
// One-burst staging buffer: read beats are written in order, then replayed
// in order on the write channel. Pointers restart at the start of every chunk.
module npu_dma_beat_buf #(
   parameter int  MAX_BURST = 16,
   parameter int  DATA_W    = 256,
   localparam int PTR_W     = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_adv,
   output logic [DATA_W-1:0] rd_data,
   output logic [PTR_W-1:0]  wr_ptr,
   output logic [PTR_W-1:0]  rd_ptr
);

   logic [DATA_W-1:0] mem [MAX_BURST];

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en)  wr_ptr <= wr_ptr + 1'b1;
         if (rd_adv) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // NOTE: the data array is deliberately not reset; every entry is written before it is read.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= wr_data;
   end

   assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/npu_dma_engine.sv
// Memory-to-memory copy engine: splits a request into 4 KB-safe AXI bursts,
// reading each chunk into a local buffer before writing it out.
module npu_dma_engine
   import npu_dma_pkg::*;
#(
   parameter int MAX_BURST = 16,
   parameter int DATA_W    = 256
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                dma_req_valid,
   output logic                dma_req_ready,
   input  logic [63:0]         dma_req_src,
   input  logic [63:0]         dma_req_dst,
   input  logic [31:0]         dma_req_bytes,
   output logic                dma_resp_done,
   output logic                dma_busy,
   output logic                m_axi_arvalid,
   input  logic                m_axi_arready,
   output logic [63:0]         m_axi_araddr,
   output logic [7:0]          m_axi_arlen,
   output logic [2:0]          m_axi_arsize,
   input  logic                m_axi_rvalid,
   output logic                m_axi_rready,
   input  logic [DATA_W-1:0]   m_axi_rdata,
   input  logic                m_axi_rlast,
   output logic                m_axi_awvalid,
   input  logic                m_axi_awready,
   output logic [63:0]         m_axi_awaddr,
   output logic [7:0]          m_axi_awlen,
   output logic [2:0]          m_axi_awsize,
   output logic                m_axi_wvalid,
   input  logic                m_axi_wready,
   output logic [DATA_W-1:0]   m_axi_wdata,
   output logic [DATA_W/8-1:0] m_axi_wstrb,
   output logic                m_axi_wlast,
   input  logic                m_axi_bvalid,
   output logic                m_axi_bready
);

   localparam int STRB_W = DATA_W / 8;
   localparam int PTR_W  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

   dma_state_e        state, state_next;
   logic [63:0]       src, dst;
   logic [27:0]       remaining, rem_next, chunk_w;
   logic [4:0]        tail, chunk, chunk_m1;
   logic              rd_last_beat, wr_last_beat, req_last_beat;
   logic [STRB_W-1:0] tail_strb;
   logic              buf_clear, buf_wr_en, buf_rd_adv;
   logic [DATA_W-1:0] buf_rd_data;
   logic [PTR_W-1:0]  buf_wr_ptr, buf_rd_ptr;

   npu_dma_beat_buf #(.MAX_BURST(MAX_BURST), .DATA_W(DATA_W)) u_beat_buf (
      .clk     (clk),
      .rst     (rst),
      .clear   (buf_clear),
      .wr_en   (buf_wr_en),
      .wr_data (m_axi_rdata),
      .rd_adv  (buf_rd_adv),
      .rd_data (buf_rd_data),
      .wr_ptr  (buf_wr_ptr),
      .rd_ptr  (buf_rd_ptr)
   );

   // Chunk is derived from registers that only move in WR_RESP, so it holds for the whole chunk.
   always_comb begin
      chunk_w = remaining;
      if (chunk_w > 28'(MAX_BURST))            chunk_w = 28'(MAX_BURST);
      if (chunk_w > 28'(beats_to_4k(src[11:0]))) chunk_w = 28'(beats_to_4k(src[11:0]));
      if (chunk_w > 28'(beats_to_4k(dst[11:0]))) chunk_w = 28'(beats_to_4k(dst[11:0]));
      chunk    = chunk_w[4:0];
      chunk_m1 = chunk - 5'd1;
      rem_next = remaining - 28'(chunk);
   end

   assign rd_last_beat  = (5'(buf_wr_ptr) == chunk_m1);
   assign wr_last_beat  = (5'(buf_rd_ptr) == chunk_m1);
   assign req_last_beat = wr_last_beat && (remaining == 28'(chunk));
   assign tail_strb     = (STRB_W'(1) << tail) - STRB_W'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         src       <= '0;
         dst       <= '0;
         remaining <= '0;
         tail      <= '0;
      end else begin
         state <= state_next;
         if (state == ST_IDLE && dma_req_valid) begin
            src       <= {dma_req_src[63:5], 5'b0};
            dst       <= {dma_req_dst[63:5], 5'b0};
            remaining <= {1'b0, dma_req_bytes[31:5]} + 28'(|dma_req_bytes[4:0]);
            tail      <= dma_req_bytes[4:0];
         end else if (state == ST_WR_RESP && m_axi_bvalid) begin
            src       <= src + {54'b0, chunk, 5'b0};
            dst       <= dst + {54'b0, chunk, 5'b0};
            remaining <= rem_next;
         end
      end
   end

   // NOTE: every output is given a default first so no path through the case infers a latch.
   always_comb begin
      state_next    = state;
      dma_req_ready = 1'b0;
      dma_resp_done = 1'b0;
      dma_busy      = (state != ST_IDLE);
      m_axi_arvalid = 1'b0;
      m_axi_araddr  = '0;
      m_axi_arlen   = '0;
      m_axi_arsize  = '0;
      m_axi_rready  = 1'b0;
      m_axi_awvalid = 1'b0;
      m_axi_awaddr  = '0;
      m_axi_awlen   = '0;
      m_axi_awsize  = '0;
      m_axi_wvalid  = 1'b0;
      m_axi_wdata   = '0;
      m_axi_wstrb   = '0;
      m_axi_wlast   = 1'b0;
      m_axi_bready  = 1'b0;
      buf_clear     = 1'b0;
      buf_wr_en     = 1'b0;
      buf_rd_adv    = 1'b0;
      case (state)
         ST_IDLE: begin
            dma_req_ready = 1'b1;
            if (dma_req_valid) state_next = (dma_req_bytes == '0) ? ST_DONE : ST_RD_ADDR;
         end
         ST_RD_ADDR: begin
            buf_clear     = 1'b1;
            m_axi_arvalid = 1'b1;
            m_axi_araddr  = src;
            m_axi_arlen   = {3'b0, chunk_m1};
            m_axi_arsize  = AXI_SIZE_32B;
            if (m_axi_arready) state_next = ST_RD_DATA;
         end
         ST_RD_DATA: begin
            m_axi_rready = 1'b1;
            buf_wr_en    = m_axi_rvalid;
            if (m_axi_rvalid && (m_axi_rlast || rd_last_beat)) state_next = ST_WR_ADDR;
         end
         ST_WR_ADDR: begin
            m_axi_awvalid = 1'b1;
            m_axi_awaddr  = dst;
            m_axi_awlen   = {3'b0, chunk_m1};
            m_axi_awsize  = AXI_SIZE_32B;
            if (m_axi_awready) state_next = ST_WR_DATA;
         end
         ST_WR_DATA: begin
            m_axi_wvalid = 1'b1;
            m_axi_wdata  = buf_rd_data;
            m_axi_wlast  = wr_last_beat;
            m_axi_wstrb  = (req_last_beat && tail != '0) ? tail_strb : '1;
            buf_rd_adv   = m_axi_wready;
            if (m_axi_wready && wr_last_beat) state_next = ST_WR_RESP;
         end
         ST_WR_RESP: begin
            m_axi_bready = 1'b1;
            if (m_axi_bvalid) state_next = (rem_next != '0) ? ST_RD_ADDR : ST_DONE;
         end
         ST_DONE: begin
            dma_resp_done = 1'b1;
            state_next    = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_npu_dma_engine.sv
// Self-checking bench for npu_dma_engine: AXI memory slave with optional
// random stalls, scoreboard queues for AR/AW/W, and a request vector table.
module tb_npu_dma_engine;

   localparam int DATA_W    = 256;
   localparam int MAX_BURST = 16;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               dma_req_valid = 1'b0;
   logic               dma_req_ready;
   logic [63:0]        dma_req_src = '0, dma_req_dst = '0;
   logic [31:0]        dma_req_bytes = '0;
   logic               dma_resp_done, dma_busy;
   logic               m_axi_arvalid, m_axi_arready = 1'b0;
   logic [63:0]        m_axi_araddr;
   logic [7:0]         m_axi_arlen;
   logic [2:0]         m_axi_arsize;
   logic               m_axi_rvalid = 1'b0, m_axi_rready;
   logic [DATA_W-1:0]  m_axi_rdata = '0;
   logic               m_axi_rlast = 1'b0;
   logic               m_axi_awvalid, m_axi_awready = 1'b0;
   logic [63:0]        m_axi_awaddr;
   logic [7:0]         m_axi_awlen;
   logic [2:0]         m_axi_awsize;
   logic               m_axi_wvalid, m_axi_wready = 1'b0;
   logic [DATA_W-1:0]  m_axi_wdata;
   logic [31:0]        m_axi_wstrb;
   logic               m_axi_wlast;
   logic               m_axi_bvalid = 1'b0, m_axi_bready;

   always #5 clk = ~clk;

   npu_dma_engine #(.MAX_BURST(MAX_BURST), .DATA_W(DATA_W)) dut (
      .clk(clk), .rst(rst),
      .dma_req_valid(dma_req_valid), .dma_req_ready(dma_req_ready),
      .dma_req_src(dma_req_src), .dma_req_dst(dma_req_dst), .dma_req_bytes(dma_req_bytes),
      .dma_resp_done(dma_resp_done), .dma_busy(dma_busy),
      .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_araddr(m_axi_araddr),
      .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
      .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_rdata(m_axi_rdata),
      .m_axi_rlast(m_axi_rlast),
      .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready), .m_axi_awaddr(m_axi_awaddr),
      .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
      .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_wdata(m_axi_wdata),
      .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
      .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
   );

   typedef struct {logic [63:0] addr; logic [7:0] len;} burst_t;
   typedef struct {logic [255:0] data; logic [31:0] strb; logic last;} wbeat_t;
   typedef struct {
      logic [63:0] src;
      logic [63:0] dst;
      logic [31:0] bytes;
      bit          stall;
      int          exp_chunks;
      logic [7:0]  exp_first_len;
      logic [31:0] exp_last_strb;
   } vec_t;

   int checks = 0, errors = 0, cyc = 0;
   logic [255:0] mem [logic [58:0]];
   burst_t ar_q[$], aw_q[$], rd_q[$], wr_q[$];
   wbeat_t w_q[$];
   logic [7:0] ar_seen[$];
   int rd_beat = 0, wr_beat = 0, b_pend = 0, done_cnt = 0, done_cyc = 0, arvalid_cnt = 0;
   bit stall_en = 0, r_fire = 0, b_fire = 0, ar_wait = 0, aw_wait = 0, w_wait = 0;
   logic [71:0]  ar_prev = '0, aw_prev = '0;
   logic [288:0] w_prev = '0;
   logic [31:0]  last_strb = '0;

   task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s at cycle %0d", name, cyc);
   endtask

   function automatic logic [255:0] pat(input logic [58:0] k);
      logic [255:0] v;
      for (int i = 0; i < 8; i++) v[i*32 +: 32] = (k[31:0] * 32'h9E3779B1) ^ (32'(i) * 32'h01010101) ^ 32'hA5A50000;
      return v;
   endfunction

   function automatic logic [255:0] rd_mem(input logic [58:0] k);
      return mem.exists(k) ? mem[k] : pat(k);
   endfunction

   function automatic bit go();
      return !stall_en || ($urandom_range(0, 3) != 0);
   endfunction

   // One cycle of the AXI slave, evaluated on the falling edge.
   task automatic tick();
      logic [58:0]  k;
      logic [255:0] v;
      burst_t       eb;
      wbeat_t       ew;
      @(negedge clk);
      cyc++;
      if (ar_wait) check("ar_stable", 320'({m_axi_arvalid, m_axi_araddr, m_axi_arlen}), 320'({1'b1, ar_prev}));
      if (aw_wait) check("aw_stable", 320'({m_axi_awvalid, m_axi_awaddr, m_axi_awlen}), 320'({1'b1, aw_prev}));
      if (w_wait)  check("w_stable", 320'({m_axi_wvalid, m_axi_wlast, m_axi_wstrb, m_axi_wdata}), 320'({1'b1, w_prev}));
      if (dma_resp_done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (m_axi_arvalid) arvalid_cnt++;

      if (!(m_axi_rvalid && !r_fire)) begin
         m_axi_rvalid = (rd_q.size() > 0) && go();
         m_axi_rdata  = '0;
         m_axi_rlast  = 1'b0;
         if (m_axi_rvalid) begin
            k = rd_q[0].addr[63:5] + 59'(rd_beat);
            m_axi_rdata = rd_mem(k);
            m_axi_rlast = (rd_beat == int'(rd_q[0].len));
         end
      end
      r_fire = m_axi_rvalid && m_axi_rready;
      if (r_fire) begin
         rd_beat++;
         if (rd_beat > int'(rd_q[0].len)) begin
            void'(rd_q.pop_front());
            rd_beat = 0;
         end
      end

      m_axi_arready = go();
      if (m_axi_arvalid && m_axi_arready) begin
         ar_seen.push_back(m_axi_arlen);
         check("ar_4k", 320'((int'(m_axi_araddr[11:0]) + (int'(m_axi_arlen) + 1) * 32) <= 4096), 320'(1));
         if (ar_q.size() == 0) fail_now("ar_unexpected");
         else begin
            eb = ar_q.pop_front();
            check("ar", 320'({m_axi_araddr, m_axi_arlen, m_axi_arsize}), 320'({eb.addr, eb.len, 3'd5}));
         end
         rd_q.push_back('{m_axi_araddr, m_axi_arlen});
      end

      m_axi_awready = go();
      if (m_axi_awvalid && m_axi_awready) begin
         if (ar_q.size() != 0 && rd_q.size() != 0) fail_now("aw_before_read_done");
         if (aw_q.size() == 0) fail_now("aw_unexpected");
         else begin
            eb = aw_q.pop_front();
            check("aw", 320'({m_axi_awaddr, m_axi_awlen, m_axi_awsize}), 320'({eb.addr, eb.len, 3'd5}));
         end
         wr_q.push_back('{m_axi_awaddr, m_axi_awlen});
      end

      if (!(m_axi_bvalid && !b_fire)) m_axi_bvalid = (b_pend > 0) && go();
      b_fire = m_axi_bvalid && m_axi_bready;
      if (b_fire) b_pend--;

      m_axi_wready = go();
      if (m_axi_wvalid && m_axi_wready) begin
         last_strb = m_axi_wstrb;
         if (w_q.size() == 0) fail_now("w_unexpected");
         else begin
            ew = w_q.pop_front();
            check("w_beat", 320'({m_axi_wlast, m_axi_wstrb, m_axi_wdata}), 320'({ew.last, ew.strb, ew.data}));
         end
         if (wr_q.size() > 0) begin
            k = wr_q[0].addr[63:5] + 59'(wr_beat);
            v = rd_mem(k);
            for (int b = 0; b < 32; b++) if (m_axi_wstrb[b]) v[b*8 +: 8] = m_axi_wdata[b*8 +: 8];
            mem[k] = v;
            wr_beat++;
            if (m_axi_wlast) begin
               void'(wr_q.pop_front());
               wr_beat = 0;
               b_pend++;
            end
         end
      end

      ar_wait = m_axi_arvalid && !m_axi_arready;
      ar_prev = {m_axi_araddr, m_axi_arlen};
      aw_wait = m_axi_awvalid && !m_axi_awready;
      aw_prev = {m_axi_awaddr, m_axi_awlen};
      w_wait  = m_axi_wvalid && !m_axi_wready;
      w_prev  = {m_axi_wlast, m_axi_wstrb, m_axi_wdata};
   endtask

   // Reference model: expected bursts and write beats for one request.
   task automatic build_exp(input logic [63:0] src, input logic [63:0] dst, input logic [31:0] bytes,
                            output int chunks, output int lat);
      logic [63:0] s, d;
      logic [27:0] rem;
      int          c, bs, bd;
      wbeat_t      wb;
      s = {src[63:5], 5'b0};
      d = {dst[63:5], 5'b0};
      rem = 28'(bytes >> 5) + 28'(bytes[4:0] != 5'd0);
      chunks = 0;
      lat = 1;
      while (rem != 0) begin
         c  = (rem > 28'(MAX_BURST)) ? MAX_BURST : int'(rem);
         bs = 128 - int'(s[11:5]);
         bd = 128 - int'(d[11:5]);
         if (bs < c) c = bs;
         if (bd < c) c = bd;
         ar_q.push_back('{s, 8'(c - 1)});
         aw_q.push_back('{d, 8'(c - 1)});
         for (int j = 0; j < c; j++) begin
            wb.data = rd_mem(s[63:5] + 59'(j));
            wb.last = (j == c - 1);
            wb.strb = '1;
            if (rem == 28'(c) && j == c - 1 && bytes[4:0] != 5'd0) wb.strb = (32'd1 << bytes[4:0]) - 32'd1;
            w_q.push_back(wb);
         end
         s = s + 64'(c * 32);
         d = d + 64'(c * 32);
         rem = rem - 28'(c);
         chunks++;
         lat += 2 * (c + 3);
      end
   endtask

   task automatic start_req(input vec_t v, output int acc);
      int budget;
      stall_en = v.stall;
      ar_seen.delete();
      done_cnt = 0;
      arvalid_cnt = 0;
      dma_req_src   = v.src;
      dma_req_dst   = v.dst;
      dma_req_bytes = v.bytes;
      dma_req_valid = 1'b1;
      budget = 0;
      while (!dma_req_ready && budget < 100) begin
         tick();
         budget++;
      end
      if (!dma_req_ready) fail_now("req_accept_timeout");
      acc = cyc;
      tick();
      dma_req_valid = 1'b0;
   endtask

   task automatic run_req(input vec_t v);
      int  chunks, lat, acc, budget;
      bit  ok;
      logic [255:0] sv, dv;
      build_exp(v.src, v.dst, v.bytes, chunks, lat);
      start_req(v, acc);
      budget = 0;
      while (done_cnt == 0 && budget < 5000) begin
         tick();
         budget++;
      end
      if (done_cnt == 0) fail_now("done_timeout");
      for (int i = 0; i < 3; i++) tick();
      check("done_pulses", 320'(done_cnt), 320'(1));
      check("idle_after", 320'({dma_busy, dma_req_ready}), 320'(2'b01));
      check("sb_empty", 320'({ar_q.size(), aw_q.size(), w_q.size()}), 320'(0));
      check("chunks", 320'(ar_seen.size()), 320'(v.exp_chunks));
      if (v.exp_chunks > 0 && ar_seen.size() > 0) check("first_arlen", 320'(ar_seen[0]), 320'(v.exp_first_len));
      if (v.bytes == 0) begin
         check("zero_latency", 320'(done_cyc - acc), 320'(1));
         check("zero_no_arvalid", 320'(arvalid_cnt), 320'(0));
      end else begin
         check("last_strb", 320'(last_strb), 320'(v.exp_last_strb));
         ok = 1;
         for (int i = 0; i * 32 < int'(v.bytes); i++) begin
            sv = rd_mem(v.src[63:5] + 59'(i));
            dv = rd_mem(v.dst[63:5] + 59'(i));
            for (int b = 0; b < 32; b++)
               if (i * 32 + b < int'(v.bytes) && sv[b*8 +: 8] != dv[b*8 +: 8]) ok = 0;
         end
         check("dst_eq_src", 320'(ok), 320'(1));
      end
      if (!v.stall) check("latency", 320'((done_cyc - acc) <= lat), 320'(1));
      ar_q.delete();
      aw_q.delete();
      w_q.delete();
   endtask

   task automatic slave_flush();
      ar_q.delete(); aw_q.delete(); w_q.delete(); rd_q.delete(); wr_q.delete();
      rd_beat = 0; wr_beat = 0; b_pend = 0;
      m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rdata = '0; m_axi_bvalid = 1'b0;
      r_fire = 0; b_fire = 0; ar_wait = 0; aw_wait = 0; w_wait = 0;
      done_cnt = 0;
   endtask

   vec_t vecs[8];
   vec_t rv;
   int   acc, budget, chunks, lat;

   initial begin
      vecs[0] = '{64'h0,                   64'h10000,  32'd256,  1'b0, 1, 8'd7,  32'hFFFFFFFF};
      vecs[1] = '{64'h100000,              64'h110000, 32'd40,   1'b0, 1, 8'd1,  32'h000000FF};
      vecs[2] = '{64'h0FC0,                64'h20000,  32'd1024, 1'b0, 3, 8'd1,  32'hFFFFFFFF};
      vecs[3] = '{64'h30000,               64'h40000,  32'd512,  1'b1, 1, 8'd15, 32'hFFFFFFFF};
      vecs[4] = '{64'h50020,               64'h60FE0,  32'd100,  1'b0, 2, 8'd0,  32'h0000000F};
      vecs[5] = '{64'h0,                   64'h70000,  32'd0,    1'b0, 0, 8'd0,  32'h0};
      vecs[6] = '{64'h7001F,               64'h80005,  32'd33,   1'b1, 1, 8'd1,  32'h00000001};
      vecs[7] = '{64'hFFFFFFFFFFFFFFC0,    64'h90000,  32'd128,  1'b1, 2, 8'd1,  32'hFFFFFFFF};

      tick();
      tick();
      check("rst_ready_busy_done", 320'({dma_req_ready, dma_busy, dma_resp_done}), 320'(3'b100));
      check("rst_valids", 320'({m_axi_arvalid, m_axi_rready, m_axi_awvalid, m_axi_wvalid, m_axi_bready}), 320'(0));
      check("rst_fields", 320'({m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_awaddr, m_axi_awlen,
                                m_axi_awsize, m_axi_wstrb, m_axi_wlast}), 320'(0));
      check("rst_wdata", 320'(m_axi_wdata), 320'(0));
      rst = 1'b0;
      tick();

      for (int i = 0; i < 8; i++) begin
         run_req(vecs[i]);
         if (i == 2 && ar_seen.size() == 3) check("arlen_seq", 320'({ar_seen[1], ar_seen[2]}), 320'({8'd15, 8'd13}));
      end

      // Reset while the write channel is mid-burst.
      rv = '{64'hA0000, 64'hB0000, 32'd512, 1'b0, 1, 8'd15, 32'hFFFFFFFF};
      build_exp(rv.src, rv.dst, rv.bytes, chunks, lat);
      start_req(rv, acc);
      budget = 0;
      while (!m_axi_wvalid && budget < 200) begin
         tick();
         budget++;
      end
      if (!m_axi_wvalid) fail_now("wdata_phase_timeout");
      tick();
      rst = 1'b1;
      #1;
      check("midrst_ctrl", 320'({dma_req_ready, dma_busy, dma_resp_done, m_axi_arvalid, m_axi_rready,
                                 m_axi_awvalid, m_axi_wvalid, m_axi_bready}), 320'(8'h80));
      check("midrst_fields", 320'({m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_awaddr, m_axi_awlen,
                                   m_axi_awsize, m_axi_wstrb, m_axi_wlast}), 320'(0));
      check("midrst_wdata", 320'(m_axi_wdata), 320'(0));
      slave_flush();
      tick();
      tick();
      check("midrst_no_done", 320'(done_cnt), 320'(0));
      rst = 1'b0;
      check("ready_after_rst", 320'(dma_req_ready), 320'(1));
      run_req('{64'hC0000, 64'hD0000, 32'd64, 1'b0, 1, 8'd1, 32'hFFFFFFFF});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
